// File: rtl/main_fsm.sv
// Multi-cycle RISC-V style main controller: one registered state, outputs decoded
// from the state with mem_ready gating the fetch enables and the store-done pulse.
module main_fsm (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic       mem_ready,
   output logic       PCUpdate,
   output logic       Branch,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [3:0] state,
   output logic       instr_done
);
   // state     | meaning
   // ----------+------------------------------------------------
   // FETCH     | read instruction, PC+4; waits on mem_ready
   // DECODE    | read regs, compute PC+imm; dispatch on op
   // MEM_ADR   | compute load/store address
   // MEM_READ  | load data access; waits on mem_ready
   // MEM_WB    | write loaded data to register file
   // MEM_WRITE | store data access; waits on mem_ready
   // EXEC_R    | register-register ALU op
   // EXEC_I    | register-immediate ALU op
   // ALU_WB    | write ALU result to register file
   // BEQ       | compare and conditionally branch
   // JAL       | jump, PC <= PC+imm, link computed next
   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADR   = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXEC_R    = 4'd6,
      S_EXEC_I    = 4'd7,
      S_ALU_WB    = 4'd8,
      S_BEQ       = 4'd9,
      S_JAL       = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   state_t st_q;
   logic   op_legal;

   always_comb begin
      op_legal = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                 (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_q <= S_FETCH;
      end else begin
         case (st_q)
            S_FETCH:     st_q <= mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
               if ((op == OP_LW) || (op == OP_SW)) st_q <= S_MEM_ADR;
               else if (op == OP_R)                st_q <= S_EXEC_R;
               else if (op == OP_I)                st_q <= S_EXEC_I;
               else if (op == OP_BEQ)              st_q <= S_BEQ;
               else if (op == OP_JAL)              st_q <= S_JAL;
               else                                st_q <= S_FETCH;
            end
            S_MEM_ADR:   st_q <= (op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  st_q <= mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    st_q <= S_FETCH;
            S_MEM_WRITE: st_q <= mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXEC_R:    st_q <= S_ALU_WB;
            S_EXEC_I:    st_q <= S_ALU_WB;
            S_ALU_WB:    st_q <= S_FETCH;
            S_BEQ:       st_q <= S_FETCH;
            S_JAL:       st_q <= S_ALU_WB;
            default:     st_q <= S_FETCH;
         endcase
      end
   end

   assign state = st_q;

   // Reset overrides the decode so no enable can fire while rst_n is low,
   // even in the cycle before the state register has reloaded FETCH.
   always_comb begin
      PCUpdate   = 1'b0;
      Branch     = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      AdrSrc     = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUOp      = 2'b00;
      instr_done = 1'b0;
      if (!rst_n) begin
         ResultSrc = 2'b10;
         ALUSrcB   = 2'b10;
      end else begin
         case (st_q)
            S_FETCH: begin
               ResultSrc = 2'b10;
               ALUSrcB   = 2'b10;
               IRWrite   = mem_ready;
               PCUpdate  = mem_ready;
            end
            S_DECODE: begin
               ALUSrcA    = 2'b01;
               ALUSrcB    = 2'b01;
               instr_done = !op_legal;
            end
            S_MEM_ADR: begin
               ALUSrcA = 2'b10;
               ALUSrcB = 2'b01;
            end
            S_MEM_READ: begin
               AdrSrc = 1'b1;
            end
            S_MEM_WB: begin
               ResultSrc  = 2'b01;
               RegWrite   = 1'b1;
               instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
               AdrSrc     = 1'b1;
               MemWrite   = 1'b1;
               instr_done = mem_ready;
            end
            S_EXEC_R: begin
               ALUSrcA = 2'b10;
               ALUOp   = 2'b10;
            end
            S_EXEC_I: begin
               ALUSrcA = 2'b10;
               ALUSrcB = 2'b01;
               ALUOp   = 2'b10;
            end
            S_ALU_WB: begin
               RegWrite   = 1'b1;
               instr_done = 1'b1;
            end
            S_BEQ: begin
               ALUSrcA    = 2'b10;
               ALUOp      = 2'b01;
               Branch     = 1'b1;
               instr_done = 1'b1;
            end
            S_JAL: begin
               ALUSrcA  = 2'b01;
               ALUSrcB  = 2'b10;
               PCUpdate = 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_main_fsm.sv
// Bench for main_fsm: directed vector table for the multi-cycle scenarios, then
// randomized ops/wait-states/resets checked against an instruction-route model.
module tb_main_fsm;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] op;
   logic       mem_ready;
   logic       PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc, instr_done;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
   logic [3:0] state;

   main_fsm dut (
      .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
      .PCUpdate(PCUpdate), .Branch(Branch), .RegWrite(RegWrite),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUOp(ALUOp), .state(state), .instr_done(instr_done)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
   localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
   localparam logic [6:0] ILL = 7'b0000000;

   typedef struct {
      logic       rst_n;
      logic [6:0] op;
      logic       mem_ready;
      logic [3:0] exp_state;
      logic [5:0] exp_en;   // {PCUpdate, Branch, RegWrite, MemWrite, IRWrite, instr_done}
   } vec_t;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: current state number plus the remaining route of the instruction.
   int m_st;
   int route[$];

   wire [14:0] dut_out = {PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc,
                          ResultSrc, ALUSrcA, ALUSrcB, ALUOp, instr_done};
   wire [5:0]  dut_en  = {PCUpdate, Branch, RegWrite, MemWrite, IRWrite, instr_done};

   function automatic bit is_legal(input logic [6:0] o);
      return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == BQ) || (o == JL);
   endfunction

   function automatic logic [14:0] model_out(input int st, input logic rst,
                                             input logic [6:0] o, input logic mr);
      logic pcu, br, rw, mw, irw, adr, dn;
      logic [1:0] rs, sa, sb, ao;
      {pcu, br, rw, mw, irw, adr, dn} = '0;
      {rs, sa, sb, ao} = '0;
      if (!rst) begin
         rs = 2'b10; sb = 2'b10;
      end else begin
         case (st)
            0:  begin rs = 2'b10; sb = 2'b10; irw = mr; pcu = mr; end
            1:  begin sa = 2'b01; sb = 2'b01; dn = !is_legal(o); end
            2:  begin sa = 2'b10; sb = 2'b01; end
            3:  begin adr = 1'b1; end
            4:  begin rs = 2'b01; rw = 1'b1; dn = 1'b1; end
            5:  begin adr = 1'b1; mw = 1'b1; dn = mr; end
            6:  begin sa = 2'b10; ao = 2'b10; end
            7:  begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
            8:  begin rw = 1'b1; dn = 1'b1; end
            9:  begin sa = 2'b10; ao = 2'b01; br = 1'b1; dn = 1'b1; end
            10: begin sa = 2'b01; sb = 2'b10; pcu = 1'b1; end
            default: ;
         endcase
      end
      return {pcu, br, rw, mw, irw, adr, rs, sa, sb, ao, dn};
   endfunction

   // Advance the model across one rising edge with the inputs currently applied.
   task automatic model_step(input logic rst, input logic [6:0] o, input logic mr);
      if (!rst) begin
         m_st = 0;
         route.delete();
      end else if ((m_st == 0 || m_st == 3 || m_st == 5) && !mr) begin
         // wait state: hold
      end else begin
         if (m_st == 1) begin
            route.delete();
            if (o == LW || o == SW) route = '{2};
            else if (o == RT)       route = '{6, 8};
            else if (o == IT)       route = '{7, 8};
            else if (o == BQ)       route = '{9};
            else if (o == JL)       route = '{10, 8};
         end else if (m_st == 2) begin
            route.delete();
            if (o == LW) route = '{3, 4};
            else         route = '{5};
         end
         if (m_st == 0)              m_st = 1;
         else if (route.size() > 0)  m_st = route.pop_front();
         else                        m_st = 0;
      end
   endtask

   // Apply inputs for one cycle, compare against the model mid-cycle, then clock.
   task automatic step(input logic r, input logic [6:0] o, input logic mr);
      logic [18:0] exp_v, act_v;
      rst_n = r; op = o; mem_ready = mr;
      @(negedge clk);
      exp_v = {m_st[3:0], model_out(m_st, r, o, mr)};
      act_v = {state, dut_out};
      n_checks++;
      if (act_v === exp_v) n_pass++;
      else $display("FAIL model_cmp t=%0t: got state=%0d out=%b, expected state=%0d out=%b",
                    $time, act_v[18:15], act_v[14:0], exp_v[18:15], exp_v[14:0]);
      model_step(r, o, mr);
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[29];

   initial begin
      vecs[0]  = '{1'b1, LW,  1'b1, 4'd0,  6'b100010};
      vecs[1]  = '{1'b1, LW,  1'b1, 4'd1,  6'b000000};
      vecs[2]  = '{1'b1, LW,  1'b1, 4'd2,  6'b000000};
      vecs[3]  = '{1'b1, LW,  1'b1, 4'd3,  6'b000000};
      vecs[4]  = '{1'b1, LW,  1'b1, 4'd4,  6'b001001};
      vecs[5]  = '{1'b1, SW,  1'b1, 4'd0,  6'b100010};
      vecs[6]  = '{1'b1, SW,  1'b1, 4'd1,  6'b000000};
      vecs[7]  = '{1'b1, SW,  1'b1, 4'd2,  6'b000000};
      vecs[8]  = '{1'b1, SW,  1'b0, 4'd5,  6'b000100};
      vecs[9]  = '{1'b1, SW,  1'b0, 4'd5,  6'b000100};
      vecs[10] = '{1'b1, SW,  1'b1, 4'd5,  6'b000101};
      vecs[11] = '{1'b1, JL,  1'b1, 4'd0,  6'b100010};
      vecs[12] = '{1'b1, JL,  1'b1, 4'd1,  6'b000000};
      vecs[13] = '{1'b1, JL,  1'b1, 4'd10, 6'b100000};
      vecs[14] = '{1'b1, JL,  1'b1, 4'd8,  6'b001001};
      vecs[15] = '{1'b1, ILL, 1'b0, 4'd0,  6'b000000};
      vecs[16] = '{1'b1, ILL, 1'b0, 4'd0,  6'b000000};
      vecs[17] = '{1'b1, ILL, 1'b0, 4'd0,  6'b000000};
      vecs[18] = '{1'b1, ILL, 1'b1, 4'd0,  6'b100010};
      vecs[19] = '{1'b1, ILL, 1'b1, 4'd1,  6'b000001};
      vecs[20] = '{1'b1, LW,  1'b1, 4'd0,  6'b100010};
      vecs[21] = '{1'b1, LW,  1'b1, 4'd1,  6'b000000};
      vecs[22] = '{1'b1, LW,  1'b1, 4'd2,  6'b000000};
      vecs[23] = '{1'b1, LW,  1'b0, 4'd3,  6'b000000};
      vecs[24] = '{1'b0, LW,  1'b0, 4'd3,  6'b000000};
      vecs[25] = '{1'b1, BQ,  1'b1, 4'd0,  6'b100010};
      vecs[26] = '{1'b1, BQ,  1'b1, 4'd1,  6'b000000};
      vecs[27] = '{1'b1, BQ,  1'b1, 4'd9,  6'b010001};
      vecs[28] = '{1'b1, BQ,  1'b0, 4'd0,  6'b000000};

      rst_n = 1'b0; op = ILL; mem_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      m_st = 0;
      route.delete();

      for (int i = 0; i < 29; i++) begin
         rst_n = vecs[i].rst_n; op = vecs[i].op; mem_ready = vecs[i].mem_ready;
         @(negedge clk);
         n_checks++;
         if (state === vecs[i].exp_state && dut_en === vecs[i].exp_en) n_pass++;
         else $display("FAIL vec[%0d]: got state=%0d en=%b, expected state=%0d en=%b",
                       i, state, dut_en, vecs[i].exp_state, vecs[i].exp_en);
         @(posedge clk);
         #1;
      end

      // Re-align the model with a reset, then replay the lw route with op scrambled
      // outside Decode/MemAdr: the scrambled ops must not disturb the route.
      step(1'b0, ILL, 1'b1);
      step(1'b1, BQ,  1'b1);
      step(1'b1, LW,  1'b1);
      step(1'b1, LW,  1'b1);
      step(1'b1, RT,  1'b0);
      step(1'b1, JL,  1'b1);
      step(1'b1, SW,  1'b1);
      n_checks++;
      if (state === 4'd0) n_pass++;
      else $display("FAIL op_ignored: got state=%0d, expected state=0", state);

      for (int n = 0; n < 3000; n++) begin
         logic [6:0] o;
         logic       mr, r;
         case ($urandom_range(0, 7))
            0: o = LW;
            1: o = SW;
            2: o = RT;
            3: o = IT;
            4: o = BQ;
            5: o = JL;
            default: o = 7'($urandom_range(0, 127));
         endcase
         if ($urandom_range(0, 1) == 0) o = op;
         mr = ($urandom_range(0, 3) != 0);
         r  = ($urandom_range(0, 59) != 0);
         step(r, o, mr);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
